// File: rtl/issue_scoreboard.sv
// In-order issue stage: one-entry issue register guarded by a per-register
// counting scoreboard, with flush and a trap state after an ILLEGAL issues.
package com_pkg;
  typedef enum logic [2:0] {
    CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILLEGAL, CLS_NOP
  } inst_class_t;

  typedef struct packed {
    logic       used;
    logic [3:0] sel;
  } decode_reg_t;

  typedef struct packed {
    inst_class_t inst_class;
    logic [3:0]  alu_op;
    logic [2:0]  funct3;
    decode_reg_t rd;
    decode_reg_t rs1;
    decode_reg_t rs2;
    logic [31:0] imm;
  } decode_instruction_t;

  typedef struct packed {
    logic        valid;
    logic [1:0]  cause;
    logic [31:0] target;
  } flush_t;
endpackage

module issue_scoreboard #(
  parameter int NUM_REGS = 16,
  parameter int CNT_W    = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         dec_valid,
  output logic                         dec_ready,
  input  com_pkg::decode_instruction_t dec_inst,
  output logic                         iss_valid,
  input  logic                         iss_ready,
  output com_pkg::decode_instruction_t iss_inst,
  input  logic                         wb_valid,
  input  logic [3:0]                   wb_sel,
  input  com_pkg::flush_t              flush,
  output logic [NUM_REGS-1:0]          busy,
  output logic                         stall_haz
);
  import com_pkg::*;

  typedef enum logic [1:0] {S_EMPTY, S_FULL, S_TRAP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t              state_q;
  decode_instruction_t inst_q;
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];

  logic writes_rd, hazard, fire, held_illegal, wb_ok;
  logic unused_flush_fields;

  // Saturating up/down step; simultaneous inc and dec cancel out.
  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic dec);
    logic [CNT_W-1:0] r;
    r = c;
    if (inc && !dec && c != CNT_MAX) r = c + CNT_ONE;
    else if (dec && !inc && c != '0) r = c - CNT_ONE;
    return r;
  endfunction

  assign unused_flush_fields = ^{flush.cause, flush.target};

  assign held_illegal = (inst_q.inst_class == CLS_ILLEGAL);
  assign writes_rd = inst_q.rd.used && (inst_q.rd.sel != 4'd0) &&
                     (inst_q.inst_class inside {CLS_ALU, CLS_LOAD, CLS_JAL, CLS_JALR});

  // Hazards look only at registered counts: a writeback frees dependents one cycle later.
  assign hazard = (inst_q.rs1.used && cnt_q[inst_q.rs1.sel] != '0) ||
                  (inst_q.rs2.used && cnt_q[inst_q.rs2.sel] != '0) ||
                  (writes_rd && cnt_q[inst_q.rd.sel] == CNT_MAX);

  assign iss_valid = (state_q == S_FULL) && !hazard && !flush.valid;
  assign fire      = iss_valid && iss_ready;
  assign dec_ready = !flush.valid &&
                     ((state_q == S_EMPTY) || ((state_q == S_FULL) && fire && !held_illegal));
  assign iss_inst  = inst_q;
  assign stall_haz = (state_q == S_FULL) && hazard;
  assign wb_ok     = wb_valid && (wb_sel != 4'd0);

  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_next(cnt_q[r],
                          fire && writes_rd && (inst_q.rd.sel == 4'(r)),
                          wb_ok && (wb_sel == 4'(r)));
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    busy = '0;
    for (int r = 1; r < NUM_REGS; r++) busy[r] = (cnt_q[r] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      inst_q  <= '0;
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
      if (flush.valid) begin
        // In-flight writes still retire, so the counters are left alone.
        state_q <= S_EMPTY;
        inst_q  <= '0;
      end else begin
        case (state_q)
          S_EMPTY: if (dec_valid) begin
            state_q <= S_FULL;
            inst_q  <= dec_inst;
          end
          S_FULL: if (fire) begin
            if (held_illegal) begin
              state_q <= S_TRAP;
            end else if (dec_valid) begin
              state_q <= S_FULL;
              inst_q  <= dec_inst;
            end else begin
              state_q <= S_EMPTY;
              inst_q  <= '0;
            end
          end
          default: state_q <= S_TRAP;
        endcase
      end
    end
  end
endmodule
